// File: rtl/p405s_mdu_pkg.sv
// p405s_mdu_pkg
// Shared definitions for the multiply/divide/MAC sequencer slice.
// Holds the PCL md opcode encodings, the sequencer state encoding, the
// default divide step count and counter width, and small opcode decode
// helpers used by the sequencer and its bench.
package p405s_mdu_pkg;

   localparam int DIV_STEPS_DEF = 32;
   localparam int CNT_W_DEF     = 6;

   typedef enum logic [2:0] {
      OP_MULLW  = 3'b000,
      OP_MULHW  = 3'b001,
      OP_MULHWU = 3'b010,
      OP_DIVW   = 3'b011,
      OP_DIVWU  = 3'b100,
      OP_MACS   = 3'b101,
      OP_MACU   = 3'b110,
      OP_RSVD   = 3'b111
   } mdOp_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MEXE   = 3'd1,
      ST_MEXE2  = 3'd2,
      ST_MEXE2B = 3'd3,
      ST_DSETUP = 3'd4,
      ST_DSTEP  = 3'd5,
      ST_DFIX   = 3'd6,
      ST_DONE   = 3'd7
   } mdState_t;

   function automatic logic isDivOp(input mdOp_t op);
      return (op == OP_DIVW) || (op == OP_DIVWU);
   endfunction

   function automatic logic isMacOp(input mdOp_t op);
      return (op == OP_MACS) || (op == OP_MACU);
   endfunction

   function automatic logic isHiWordOp(input mdOp_t op);
      return (op == OP_MULHW) || (op == OP_MULHWU);
   endfunction

   function automatic logic isSignedOp(input mdOp_t op);
      return (op == OP_MULLW) || (op == OP_MULHW) || (op == OP_DIVW) || (op == OP_MACS);
   endfunction

endpackage

// File: rtl/p405s_mdu_stepCnt.sv
// p405s_mdu_stepCnt
// Loadable down-counter that paces the divide iterations.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           load i_loadVal (has priority over decrement)
//   i_loadVal        value loaded at the start of the divide steps
//   i_dec            decrement request; ignored once the count is zero
//   o_zero           current count is zero
//   o_nextZero       count will be zero after the coming clock edge
import p405s_mdu_pkg::*;

module p405s_mdu_stepCnt #(
   parameter int W = CNT_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_loadVal,
   input  logic         i_dec,
   output logic         o_zero,
   output logic         o_nextZero
);

   logic [W-1:0] r_count;

   // The count saturates at zero so a stray decrement can never wrap it
   // back to the top and stretch a divide.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

   // Look-ahead zero lets the sequencer register the last-step strobe so it
   // lines up with the cycle in which the count actually reads zero.
   always_comb begin
      o_nextZero = o_zero;
      if (i_load) begin
         o_nextZero = (i_loadVal == '0);
      end else if (i_dec && (r_count == W'(1))) begin
         o_nextZero = 1'b1;
      end
   end

endmodule

// File: rtl/p405s_mdu_sequencer.sv
// p405s_mdu_sequencer
// Control sequencer for the shared multiply/divide/MAC adder datapath.
// Takes one md op from PCL, walks the exe/exe2 multiply passes or the
// non-restoring divide iterations, and produces the registered per-cycle
// enables that the datapath steering gates decode into adder mux selects.
// Ports:
//   i_CB, i_resetCore_NEG        core clock, asynchronous active-low reset
//   i_PCL_mdIssue/mdOp           op valid and opcode
//   i_PCL_mdFlush                abort whatever is in flight
//   i_PCL_mdTake                 PCL consumes the result held in DONE
//   i_PCL_xerOvEn                OE form of the instruction
//   i_mr16BitOprnd/md16BitOprnd  operand fits in 16 bits, sampled at issue
//   i_divisorZero/divOvflCase    divide exception cases, sampled in DSETUP
//   o_mdIssueAccept              an op may be issued this cycle
//   o_PCL_*                      datapath enables (paired copies are identical,
//                                _NEG copies are the complement)
//   o_divLastStOrSt0L2_1/_NEG    first or last divide step strobe
//   o_mdBusy/mdDone/mdOvfl       busy, result valid, overflow result
import p405s_mdu_pkg::*;

module p405s_mdu_sequencer #(
   parameter int DIV_STEPS = DIV_STEPS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic       i_CB,
   input  logic       i_resetCore_NEG,
   input  logic       i_PCL_mdIssue,
   input  logic [2:0] i_PCL_mdOp,
   input  logic       i_PCL_mdFlush,
   input  logic       i_PCL_mdTake,
   input  logic       i_PCL_xerOvEn,
   input  logic       i_mr16BitOprnd,
   input  logic       i_md16BitOprnd,
   input  logic       i_divisorZero,
   input  logic       i_divOvflCase,
   output logic       o_mdIssueAccept,
   output logic [1:0] o_PCL_exeMultEn_NEG,
   output logic [1:0] o_PCL_exeMultEnForMuxSel,
   output logic [1:0] o_PCL_exe2MacOrMultEn_NEG,
   output logic [1:0] o_PCL_exe2MacOrMultEnForMS,
   output logic       o_PCL_exe2MultEn,
   output logic       o_PCL_exe2MultHiWd,
   output logic       o_PCL_exe2SignedOp,
   output logic       o_PCL_exe2XerOvEn,
   output logic [1:0] o_PCL_exeDivEnForMuxSel,
   output logic       o_divLastStOrSt0L2_1,
   output logic       o_divLastStOrSt0L2_NEG,
   output logic       o_mdBusy,
   output logic       o_mdDone,
   output logic       o_mdOvfl
);

   mdState_t r_state;
   mdOp_t    r_op;
   logic     r_short;
   logic     r_xerOvEn;
   logic     r_acceptIdle;
   logic [1:0] r_exeMultEn;
   logic [1:0] r_exeMultEn_NEG;
   logic [1:0] r_exe2Pass;
   logic [1:0] r_exe2Pass_NEG;
   logic     r_exe2MultEn;
   logic     r_exe2MultHiWd;
   logic     r_exe2SignedOp;
   logic     r_exe2XerOvEn;
   logic [1:0] r_exeDivEn;
   logic     r_divLast;
   logic     r_divLast_NEG;
   logic     r_mdBusy;
   logic     r_mdDone;
   logic     r_mdOvfl;

   mdState_t w_nextState;
   mdState_t w_issueState;
   mdOp_t    w_inOp;
   mdOp_t    w_nextOp;
   logic     w_issueTaken;
   logic     w_nextShort;
   logic     w_nextXer;
   logic     w_ovflCase;
   logic     w_nextOvfl;
   logic     w_nextExe2;
   logic     w_cntLoad;
   logic     w_cntDec;
   logic     w_cntZero;
   logic     w_cntNextZero;

   assign w_inOp          = mdOp_t'(i_PCL_mdOp);
   assign o_mdIssueAccept = r_acceptIdle | ((r_state == ST_DONE) & i_PCL_mdTake);
   assign w_issueTaken    = i_PCL_mdIssue & o_mdIssueAccept & ~i_PCL_mdFlush;

   // Attributes of the op the sequencer will be working on next cycle: a
   // freshly issued op replaces the latched one, otherwise the latch holds.
   // MAC ops always take the 16-bit (single exe2 pass) route.
   assign w_nextOp    = w_issueTaken ? w_inOp : r_op;
   assign w_nextShort = w_issueTaken ? (i_mr16BitOprnd | i_md16BitOprnd | isMacOp(w_inOp)) : r_short;
   assign w_nextXer   = w_issueTaken ? i_PCL_xerOvEn : r_xerOvEn;
   assign w_ovflCase  = i_divisorZero | ((r_op == OP_DIVW) & i_divOvflCase);

   // First state of a newly issued op. The reserved encoding has no
   // datapath work and simply completes.
   always_comb begin
      w_issueState = ST_MEXE;
      if (isDivOp(w_inOp)) begin
         w_issueState = ST_DSETUP;
      end else if (w_inOp == OP_RSVD) begin
         w_issueState = ST_DONE;
      end
   end

   // Next-state logic. Flush outranks everything, including an issue
   // arriving in the same cycle. DONE chains straight into the next op when
   // take and issue coincide, so back-to-back ops see no idle bubble.
   always_comb begin
      w_nextState = r_state;
      if (i_PCL_mdFlush) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (w_issueTaken) w_nextState = w_issueState;
            ST_MEXE:   w_nextState = ST_MEXE2;
            ST_MEXE2:  w_nextState = r_short ? ST_DONE : ST_MEXE2B;
            ST_MEXE2B: w_nextState = ST_DONE;
            ST_DSETUP: w_nextState = w_ovflCase ? ST_DONE : ST_DSTEP;
            ST_DSTEP:  w_nextState = w_cntZero ? ST_DFIX : ST_DSTEP;
            ST_DFIX:   w_nextState = ST_DONE;
            ST_DONE: begin
               if (i_PCL_mdTake) begin
                  w_nextState = w_issueTaken ? w_issueState : ST_IDLE;
               end
            end
            default:   w_nextState = ST_IDLE;
         endcase
      end
   end

   // The overflow result is decided once in DSETUP and then held for as
   // long as the sequencer waits in DONE for PCL to take it.
   always_comb begin
      w_nextOvfl = 1'b0;
      if (w_nextState == ST_DONE) begin
         if (r_state == ST_DSETUP) begin
            w_nextOvfl = w_ovflCase;
         end else if ((r_state == ST_DONE) && !i_PCL_mdTake) begin
            w_nextOvfl = r_mdOvfl;
         end
      end
   end

   assign w_nextExe2 = (w_nextState == ST_MEXE2) || (w_nextState == ST_MEXE2B);
   assign w_cntLoad  = (r_state == ST_DSETUP) && (w_nextState == ST_DSTEP);
   assign w_cntDec   = (r_state == ST_DSTEP);

   p405s_mdu_stepCnt #(
      .W (CNT_W)
   ) u_stepCnt (
      .i_clk      (i_CB),
      .i_rst_n    (i_resetCore_NEG),
      .i_load     (w_cntLoad),
      .i_loadVal  (CNT_W'(DIV_STEPS - 1)),
      .i_dec      (w_cntDec),
      .o_zero     (w_cntZero),
      .o_nextZero (w_cntNextZero)
   );

   // State, latched op attributes and every output flop. Outputs are
   // decoded from the next state so each enable is a clean flop output in
   // the cycle its state is active. Fan-out copies and the _NEG partners
   // are separate flops loaded from the same decode.
   always_ff @(posedge i_CB or negedge i_resetCore_NEG) begin
      if (!i_resetCore_NEG) begin
         r_state         <= ST_IDLE;
         r_op            <= OP_MULLW;
         r_short         <= 1'b0;
         r_xerOvEn       <= 1'b0;
         r_acceptIdle    <= 1'b1;
         r_exeMultEn     <= 2'b00;
         r_exeMultEn_NEG <= 2'b11;
         r_exe2Pass      <= 2'b00;
         r_exe2Pass_NEG  <= 2'b11;
         r_exe2MultEn    <= 1'b0;
         r_exe2MultHiWd  <= 1'b0;
         r_exe2SignedOp  <= 1'b0;
         r_exe2XerOvEn   <= 1'b0;
         r_exeDivEn      <= 2'b00;
         r_divLast       <= 1'b0;
         r_divLast_NEG   <= 1'b1;
         r_mdBusy        <= 1'b0;
         r_mdDone        <= 1'b0;
         r_mdOvfl        <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_issueTaken) begin
            r_op      <= w_inOp;
            r_short   <= w_nextShort;
            r_xerOvEn <= w_nextXer;
         end
         r_acceptIdle    <= (w_nextState == ST_IDLE);
         r_exeMultEn     <= {2{w_nextState == ST_MEXE}};
         r_exeMultEn_NEG <= {2{w_nextState != ST_MEXE}};
         r_exe2Pass      <= {2{w_nextExe2}};
         r_exe2Pass_NEG  <= {2{~w_nextExe2}};
         r_exe2MultEn    <= w_nextExe2;
         r_exe2MultHiWd  <= (w_nextState == ST_MEXE2B) && isHiWordOp(w_nextOp);
         r_exe2SignedOp  <= (w_nextState != ST_IDLE) && isSignedOp(w_nextOp);
         r_exe2XerOvEn   <= w_nextXer && (w_nextExe2 || w_nextOvfl);
         r_exeDivEn      <= {2{(w_nextState == ST_DSTEP) || (w_nextState == ST_DFIX)}};
         r_divLast       <= (w_nextState == ST_DSETUP) || ((w_nextState == ST_DSTEP) && w_cntNextZero);
         r_divLast_NEG   <= !((w_nextState == ST_DSETUP) || ((w_nextState == ST_DSTEP) && w_cntNextZero));
         r_mdBusy        <= (w_nextState != ST_IDLE) && (w_nextState != ST_DONE);
         r_mdDone        <= (w_nextState == ST_DONE);
         r_mdOvfl        <= w_nextOvfl;
      end
   end

   assign o_PCL_exeMultEn_NEG        = r_exeMultEn_NEG;
   assign o_PCL_exeMultEnForMuxSel   = r_exeMultEn;
   assign o_PCL_exe2MacOrMultEn_NEG  = r_exe2Pass_NEG;
   assign o_PCL_exe2MacOrMultEnForMS = r_exe2Pass;
   assign o_PCL_exe2MultEn           = r_exe2MultEn;
   assign o_PCL_exe2MultHiWd         = r_exe2MultHiWd;
   assign o_PCL_exe2SignedOp         = r_exe2SignedOp;
   assign o_PCL_exe2XerOvEn          = r_exe2XerOvEn;
   assign o_PCL_exeDivEnForMuxSel    = r_exeDivEn;
   assign o_divLastStOrSt0L2_1       = r_divLast;
   assign o_divLastStOrSt0L2_NEG     = r_divLast_NEG;
   assign o_mdBusy                   = r_mdBusy;
   assign o_mdDone                   = r_mdDone;
   assign o_mdOvfl                   = r_mdOvfl;

endmodule
